instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
// - Instruction fetch queue feeding the single-cycle RV32 CPU core.
// - Sits directly upstream of the core's instr input and buffers encoded 32-bit instructions
//   (ADDI/ADD/SUB/AND/OR/SLT) from a producer (program loader or stimulus driver).
// - Issues at most one instruction per clock, with a matching pc.
// - Issues ADDI x0,x0,0 (NOP) bubbles when empty or stalled.
// PARAMETERS
// - DEPTH     8             queue entries; power of two, >= 2
// - RESET_PC  32'h00000000  pc of first issued instruction after reset
// - NOP_INSTR 32'h00000013  bubble encoding (addi x0,x0,0)
// PORTS
// - clk        in   1        single clock; all state on posedge
// - rst        in   1        synchronous, active-high reset
// - in_valid   in   1        producer has instruction on in_instr
// - in_instr   in   32       encoded instruction from producer
// - in_ready   out  1        queue can accept; push = in_valid & in_ready
// - cpu_stall  in   1        hold issue register and pop pointer
// - instr      out  32       registered instruction to core
// - instr_vld  out  1        instr is a real queued instruction (0 = bubble)
// - pc         out  32       registered pc tagged to instr
// - count      out  $clog2(DEPTH+1)  entries currently stored
// - full       out  1        count == DEPTH
// - empty      out  1        count == 0
// - illegal    out  1        registered flag aligned with instr (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, instr=NOP_INSTR, instr_vld=0, pc=RESET_PC,
//   next_pc=RESET_PC, illegal=0. Queued contents discarded. Reset mid-burst drops everything, no partial issue.
// - in_ready = !rst & (count < DEPTH), combinational from registered count only.
//   No ready increase from a same-cycle pop.
// - Push: on posedge with in_valid & in_ready, mem[wr_ptr] <= in_instr; wr_ptr wraps modulo DEPTH.
// - Issue, per posedge when !cpu_stall:
//   - count > 0: instr <= mem[rd_ptr]; instr_vld <= 1; pc <= next_pc; next_pc <= next_pc + 4 (32-bit wrap);
//     rd_ptr wraps modulo DEPTH.
//   - count == 0: instr <= NOP_INSTR; instr_vld <= 0; pc and next_pc unchanged.
//   - No bypass: an entry pushed at edge k issues at edge k+1 at the earliest (1-cycle latency).
// - cpu_stall=1: instr, instr_vld, pc, illegal and rd_ptr hold; pushes still accepted.
// - Simultaneous push and pop: count unchanged; legal when full (pop frees, push blocked that cycle by in_ready=0).
// - full/empty derived from count. count never exceeds DEPTH, never underflows.
// - pc wrap: 32'hFFFFFFFC + 4 -> 32'h00000000, no flag.
// CONFIGURATION
// - Macro FETCHQ_OPCODE_CHECK_EN.
// - Defined: on issue, opcode[6:0] is checked. Legal encodings:
//   - 7'b0010011 with funct3=000.
//   - 7'b0110011 with {funct7,funct3} in {0000000_000, 0100000_000, 0000000_111, 0000000_110, 0000000_010}.
// - Illegal entry handling: instr <= NOP_INSTR; instr_vld <= 1; illegal <= 1 for that issue; pc still advances.
// - Legal issue or bubble: illegal <= 0.
// - Undefined: no check logic; instructions pass unchanged; illegal tied 0.
// TESTING
// - Reset then push 32'h00500093 (addi x1,x0,5): next edge instr=32'h00500093, instr_vld=1, pc=0.
//   Following edge instr=32'h00000013, instr_vld=0.
// - Push 9 back-to-back with cpu_stall=1: 8 accepted, full=1, in_ready=0 on 9th.
//   Release stall: 8 issues at pc 0,4,...,28 in push order.
// - Full queue, in_valid=1, stall=0 continuously: one push accepted every cycle after first pop.
//   count stays 8 or 7; no loss or duplication.
// - Stall for 3 cycles mid-stream: instr/pc frozen 3 cycles; resumes with next entry, pc +4.
// - Assert rst with count=5: after edge count=0, empty=1, instr=NOP, pc=RESET_PC; no stale entry ever issues.
// - With FETCHQ_OPCODE_CHECK_EN: push 32'h00000033 then 32'h0000006F.
//   Issue 1 illegal=0; issue 2 instr=NOP, instr_vld=1, illegal=1, pc=4.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers 32-bit instructions and issues one per clock with a pc tag.
// Optional opcode legality check is enabled by defining FETCHQ_OPCODE_CHECK_EN.
module instr_fetch_queue #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    input  logic                       cpu_stall,
    output logic [31:0]                instr,
    output logic                       instr_vld,
    output logic [31:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr;
    logic          r_instr_vld;
    logic [31:0]   r_pc;
    logic [31:0]   r_next_pc;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready = !rst && (r_count < DEPTH_C);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !cpu_stall && (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCHQ_OPCODE_CHECK_EN
    logic r_illegal;
    logic w_head_legal;

    always_comb begin
        w_head_legal = 1'b0;
        unique case (w_head[6:0])
            7'b0010011: w_head_legal = (w_head[14:12] == 3'b000);
            7'b0110011: w_head_legal = ({w_head[31:25], w_head[14:12]} inside
                            {10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                             10'b0000000_110, 10'b0000000_010});
            default:    w_head_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= NOP_INSTR;
            r_instr_vld <= 1'b0;
            r_pc        <= RESET_PC;
            r_next_pc   <= RESET_PC;
            r_illegal   <= 1'b0;
        end else if (!cpu_stall) begin
            if (r_count != '0) begin
                // Illegal entries still consume a slot and a pc, but issue as a flagged NOP.
                r_instr     <= w_head_legal ? w_head : NOP_INSTR;
                r_instr_vld <= 1'b1;
                r_illegal   <= !w_head_legal;
                r_pc        <= r_next_pc;
                r_next_pc   <= r_next_pc + 32'd4;
            end else begin
                r_instr     <= NOP_INSTR;
                r_instr_vld <= 1'b0;
                r_illegal   <= 1'b0;
            end
        end
    end

    assign illegal = r_illegal;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= NOP_INSTR;
            r_instr_vld <= 1'b0;
            r_pc        <= RESET_PC;
            r_next_pc   <= RESET_PC;
        end else if (!cpu_stall) begin
            if (r_count != '0) begin
                r_instr     <= w_head;
                r_instr_vld <= 1'b1;
                r_pc        <= r_next_pc;
                r_next_pc   <= r_next_pc + 32'd4;
            end else begin
                r_instr     <= NOP_INSTR;
                r_instr_vld <= 1'b0;
            end
        end
    end

    assign illegal = 1'b0;
`endif

    assign instr     = r_instr;
    assign instr_vld = r_instr_vld;
    assign pc        = r_pc;
    assign count     = r_count;
    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a queue-based reference model predicts each edge's
// outputs; a separate monitor compares them against the DUT one cycle-transaction at a time.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        cpu_stall = 1'b0;
    logic [31:0] instr;
    logic        instr_vld;
    logic [31:0] pc;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        illegal;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic [31:0] pc;
        logic        ill;
        int          cnt;
        logic        rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    logic [31:0] m_instr = NOP;
    logic        m_vld   = 1'b0;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_next  = RESET_PC;
    logic        m_ill   = 1'b0;
    int          cyc_no  = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .cpu_stall(cpu_stall), .instr(instr), .instr_vld(instr_vld), .pc(pc), .count(count),
        .full(full), .empty(empty), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL cycle %0d %s: got %h expected %h", cyc_no, name, act, req);
    endtask

    function automatic logic legal(input logic [31:0] w);
`ifdef FETCHQ_OPCODE_CHECK_EN
        logic [9:0] f;
        f = {w[31:25], w[14:12]};
        if (w[6:0] == 7'b0010011) return w[14:12] == 3'b000;
        if (w[6:0] == 7'b0110011)
            return f == 10'b0000000_000 || f == 10'b0100000_000 || f == 10'b0000000_111 ||
                   f == 10'b0000000_110 || f == 10'b0000000_010;
        return 1'b0;
`else
        return (w === w);
`endif
    endfunction

    // Reference model: the queue holds what is stored; one pop per unstalled edge.
    always @(posedge clk) begin
        exp_t        e;
        int          pre;
        logic [31:0] w;
        pre = mq.size();
        if (rst) begin
            mq.delete();
            m_instr = NOP; m_vld = 1'b0; m_pc = RESET_PC; m_next = RESET_PC; m_ill = 1'b0;
        end else begin
            if (!cpu_stall) begin
                if (pre > 0) begin
                    w = mq.pop_front();
                    m_vld = 1'b1;
                    m_pc = m_next;
                    m_next = m_next + 32'd4;
                    if (legal(w)) begin m_instr = w;   m_ill = 1'b0; end
                    else          begin m_instr = NOP; m_ill = 1'b1; end
                end else begin
                    m_instr = NOP; m_vld = 1'b0; m_ill = 1'b0;
                end
            end
            if (in_valid && pre < DEPTH) mq.push_back(in_instr);
        end
        e.instr = m_instr; e.vld = m_vld; e.pc = m_pc; e.ill = m_ill;
        e.cnt = mq.size(); e.rdy = !rst && (mq.size() < DEPTH);
        exp_q.push_back(e);
    end

    // Monitor: one transaction per edge, sampled away from the clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr",     instr,          e.instr);
            chk("instr_vld", 32'(instr_vld), 32'(e.vld));
            chk("pc",        pc,             e.pc);
            chk("illegal",   32'(illegal),   32'(e.ill));
            chk("count",     32'(count),     32'(e.cnt));
            chk("full",      32'(full),      32'(e.cnt == DEPTH));
            chk("empty",     32'(empty),     32'(e.cnt == 0));
            chk("in_ready",  32'(in_ready),  32'(e.rdy));
        end
    end

    task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic s);
        @(negedge clk);
        rst = r; in_valid = v; in_instr = d; cpu_stall = s;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [9:0]  f [5];
        int          k;
        f[0] = 10'b0000000_000; f[1] = 10'b0100000_000; f[2] = 10'b0000000_111;
        f[3] = 10'b0000000_110; f[4] = 10'b0000000_010;
        w = $urandom();
        case ($urandom_range(0, 3))
            0: w = {w[31:15], 3'b000, w[11:7], 7'b0010011};
            1: begin
                k = $urandom_range(0, 4);
                w = {f[k][9:3], w[24:15], f[k][2:0], w[11:7], 7'b0110011};
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        // Single push then bubble.
        drive(0, 1, 32'h00500093, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // Nine pushes under stall, then drain.
        for (int i = 0; i < 9; i++) drive(0, 1, 32'h00100093 + (i << 20), 1);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
        // Fill, then stream with continuous valid.
        for (int i = 0; i < 8; i++) drive(0, 1, rand_instr(), 1);
        for (int i = 0; i < 20; i++) drive(0, 1, rand_instr(), 0);
        // Stall three cycles mid-stream.
        for (int i = 0; i < 3; i++) drive(0, 1, rand_instr(), 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
        // Reset with five entries stored.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, rand_instr(), 1);
        drive(1, 1, rand_instr(), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
        // Legal R-type followed by JAL.
        drive(1, 0, 0, 0);
        drive(0, 1, 32'h00000033, 0);
        drive(0, 1, 32'h0000006F, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rand_instr(),
                  $urandom_range(0, 3) == 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
